// File: rtl/fk_sbox_stage.sv
// Back half of the S-DES Fk round: (EP(R) ^ SK) -> S0/S1 -> P4 -> XOR into L.
// Two-entry valid/ready pipeline; the output comes straight from the stage-2 register.
module fk_sbox_stage #(
    parameter bit SWAP_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       InValid,
    output logic       InReady,
    input  logic [7:0] InByte,
    input  logic [7:0] EpByte,
    input  logic [7:0] SubKey,
    output logic       OutValid,
    input  logic       OutReady,
    output logic [7:0] Out
);

    // Row index {row, col} -> 2-bit S-box entry; sel=0 selects S0, sel=1 selects S1.
    function automatic logic [1:0] sbox_lookup(input logic sel, input logic [3:0] idx);
        logic [1:0] val;
        val = 2'd0;
        if (!sel) begin
            case (idx)
                4'd0:  val = 2'd1;  4'd1:  val = 2'd0;  4'd2:  val = 2'd3;  4'd3:  val = 2'd2;
                4'd4:  val = 2'd3;  4'd5:  val = 2'd2;  4'd6:  val = 2'd1;  4'd7:  val = 2'd0;
                4'd8:  val = 2'd0;  4'd9:  val = 2'd2;  4'd10: val = 2'd1;  4'd11: val = 2'd3;
                4'd12: val = 2'd3;  4'd13: val = 2'd1;  4'd14: val = 2'd3;  4'd15: val = 2'd2;
                default: val = 2'd0;
            endcase
        end else begin
            case (idx)
                4'd0:  val = 2'd0;  4'd1:  val = 2'd1;  4'd2:  val = 2'd2;  4'd3:  val = 2'd3;
                4'd4:  val = 2'd2;  4'd5:  val = 2'd0;  4'd6:  val = 2'd1;  4'd7:  val = 2'd3;
                4'd8:  val = 2'd3;  4'd9:  val = 2'd0;  4'd10: val = 2'd1;  4'd11: val = 2'd0;
                4'd12: val = 2'd2;  4'd13: val = 2'd1;  4'd14: val = 2'd0;  4'd15: val = 2'd3;
                default: val = 2'd0;
            endcase
        end
        return val;
    endfunction

    logic       s1_valid_q;
    logic [7:0] x_q;
    logic [3:0] l_q;
    logic [3:0] r_q;
    logic       s2_valid_q;
    logic [7:0] out_q;

    logic       adv1;
    logic       adv2;
    logic [1:0] sbox_out [2];
    logic [3:0] p4_in;
    logic [3:0] p4_out;
    logic [3:0] new_l;
    logic [7:0] out_d;

    assign adv2 = !s2_valid_q || OutReady;
    assign adv1 = !s1_valid_q || adv2;
    // A beat presented during reset is never taken.
    assign InReady  = adv1 && !reset;
    assign OutValid = s2_valid_q;
    assign Out      = out_q;

    // Nibble bits are MSB-first: nib[3]=bit1 .. nib[0]=bit4; row={b1,b4}, col={b2,b3}.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sbox
        logic [3:0] nib;
        assign nib          = x_q[7-4*gi -: 4];
        assign sbox_out[gi] = sbox_lookup(gi == 1, {nib[3], nib[0], nib[2], nib[1]});
    end

    assign p4_in  = {sbox_out[0], sbox_out[1]};
    // P4 = (2,4,3,1) with input bit k living at p4_in[4-k].
    assign p4_out = {p4_in[2], p4_in[0], p4_in[1], p4_in[3]};
    assign new_l  = l_q ^ p4_out;
    assign out_d  = SWAP_OUT ? {r_q, new_l} : {new_l, r_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            x_q        <= 8'h00;
            l_q        <= 4'h0;
            r_q        <= 4'h0;
            s2_valid_q <= 1'b0;
            out_q      <= 8'h00;
        end else begin
            if (adv1) begin
                s1_valid_q <= InValid;
                x_q        <= EpByte ^ SubKey;
                l_q        <= InByte[7:4];
                r_q        <= InByte[3:0];
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_q <= out_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fk_sbox_stage.sv
// Directed bench for fk_sbox_stage: hand-computed vectors, S-box sweep,
// backpressure, random-stall scoreboard and mid-stream reset.
module tb_fk_sbox_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       InValid;
    logic       InReady, InReady_sw;
    logic [7:0] InByte, EpByte, SubKey;
    logic       OutValid, OutValid_sw;
    logic       OutReady;
    logic [7:0] Out, Out_sw;

    always #5 clk = ~clk;

    fk_sbox_stage #(.SWAP_OUT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
        .InByte(InByte), .EpByte(EpByte), .SubKey(SubKey),
        .OutValid(OutValid), .OutReady(OutReady), .Out(Out)
    );

    fk_sbox_stage #(.SWAP_OUT(1'b1)) u_dut_sw (
        .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady_sw),
        .InByte(InByte), .EpByte(EpByte), .SubKey(SubKey),
        .OutValid(OutValid_sw), .OutReady(OutReady), .Out(Out_sw)
    );

    int n_pass  = 0;
    int n_total = 0;

    int s0_tab [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    int s1_tab [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    typedef struct {
        logic [7:0] in_b;
        logic [7:0] ep;
        logic [7:0] sk;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Straight transcription of the round function in MSB-first bit terms.
    function automatic logic [7:0] model(input logic [7:0] in_b, input logic [7:0] ep,
                                         input logic [7:0] sk);
        logic [7:0] x;
        logic [1:0] a, b;
        logic [3:0] f;
        int r0, c0, r1, c1;
        x  = ep ^ sk;
        r0 = 2 * x[7] + x[4];
        c0 = 2 * x[6] + x[5];
        r1 = 2 * x[3] + x[0];
        c1 = 2 * x[2] + x[1];
        a  = 2'(s0_tab[r0][c0]);
        b  = 2'(s1_tab[r1][c1]);
        // P4 input bits 1..4 = a[1], a[0], b[1], b[0]; output = (2,4,3,1).
        f  = {a[0], b[0], b[1], a[1]};
        return {in_b[7:4] ^ f, in_b[3:0]};
    endfunction

    function automatic logic [7:0] swp(input logic [7:0] v);
        return {v[3:0], v[7:4]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        InValid = 1'b1;
        InByte  = v.in_b;
        EpByte  = v.ep;
        SubKey  = v.sk;
    endtask

    initial begin
        int         accepted;
        int         cycles;
        logic       pending;
        logic       hold_prev;
        logic [7:0] out_prev;
        logic [7:0] e;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h80};
        vecs[1] = '{8'h00, 8'h00, 8'hFF, 8'h70};
        vecs[2] = '{8'hA5, 8'h00, 8'h00, 8'h25};
        vecs[3] = '{8'h00, 8'h0F, 8'h00, 8'hE0};
        vecs[4] = '{8'h3C, 8'hF0, 8'h00, 8'h2C};
        vecs[5] = '{8'h99, 8'h55, 8'h33, 8'hE9};
        vecs[6] = '{8'h00, 8'h90, 8'h00, 8'h90};
        vecs[7] = '{8'h0F, 8'h09, 8'h00, 8'hAF};

        reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        InByte = 8'h00; EpByte = 8'h00; SubKey = 8'h00;
        step(); step();
        check("rst_outvalid", {31'd0, OutValid}, 32'd0);
        check("rst_out", {24'd0, Out}, 32'd0);
        check("rst_out_sw", {24'd0, Out_sw}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_inready", {31'd0, InReady}, 32'd1);

        // Directed vectors, one at a time, 2-cycle latency
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_inready", i), {31'd0, InReady}, 32'd1);
            step();
            InValid = 1'b0;
            #1;
            check($sformatf("vec%0d_lat1", i), {31'd0, OutValid}, 32'd0);
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, OutValid}, 32'd1);
            check($sformatf("vec%0d_out", i), {24'd0, Out}, {24'd0, vecs[i].exp});
            check($sformatf("vec%0d_out_sw", i), {24'd0, Out_sw}, {24'd0, swp(vecs[i].exp)});
        end

        // Full S-box sweep at one beat per cycle
        OutReady = 1'b1;
        for (int i = 0; i < 258; i++) begin
            if (i < 256) begin
                InValid = 1'b1; InByte = 8'hF0; EpByte = 8'(i); SubKey = 8'h00;
            end else begin
                InValid = 1'b0;
            end
            #1;
            if (i < 256) check($sformatf("sweep%0d_inready", i), {31'd0, InReady}, 32'd1);
            if (i >= 2) begin
                check($sformatf("sweep%0d_valid", i - 2), {31'd0, OutValid}, 32'd1);
                check($sformatf("sweep%0d_out", i - 2), {24'd0, Out},
                      {24'd0, model(8'hF0, 8'(i - 2), 8'h00)});
            end
            step();
        end
        step(); step();

        // Backpressure: two beats fill the pipe, third is refused until drain
        OutReady = 1'b0;
        drive(vecs[0]); #1;
        check("bp_acc0", {31'd0, InReady}, 32'd1);
        step();
        drive(vecs[1]); #1;
        check("bp_acc1", {31'd0, InReady}, 32'd1);
        step();
        drive(vecs[2]); #1;
        check("bp_full_inready", {31'd0, InReady}, 32'd0);
        check("bp_full_valid", {31'd0, OutValid}, 32'd1);
        check("bp_full_out", {24'd0, Out}, {24'd0, vecs[0].exp});
        step();
        check("bp_hold_inready", {31'd0, InReady}, 32'd0);
        check("bp_hold_out", {24'd0, Out}, {24'd0, vecs[0].exp});
        OutReady = 1'b1;
        #1;
        check("bp_drain_inready", {31'd0, InReady}, 32'd1);
        step();
        InValid = 1'b0;
        check("bp_out1", {24'd0, Out}, {24'd0, vecs[1].exp});
        step();
        check("bp_out2", {24'd0, Out}, {24'd0, vecs[2].exp});
        check("bp_out2_valid", {31'd0, OutValid}, 32'd1);
        step();
        check("bp_empty", {31'd0, OutValid}, 32'd0);

        // Random stalls with scoreboard and hold-stability checks
        accepted = 0; cycles = 0; pending = 1'b0; hold_prev = 1'b0; out_prev = 8'h00;
        while (accepted < 1000 && cycles < 20000) begin
            if (!pending) begin
                InValid = ($urandom_range(3) != 0);
                InByte  = 8'($urandom);
                EpByte  = 8'($urandom);
                SubKey  = 8'($urandom);
            end
            OutReady = ($urandom_range(2) != 0);
            #1;
            if (hold_prev) begin
                check("rnd_hold_valid", {31'd0, OutValid}, 32'd1);
                check("rnd_hold_out", {24'd0, Out}, {24'd0, out_prev});
            end
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rnd_extra: got output %0h, expected none", Out);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_out", {24'd0, Out}, {24'd0, e});
                end
            end
            if (InValid && InReady) begin
                exp_q.push_back(model(InByte, EpByte, SubKey));
                accepted++;
            end
            pending   = InValid && !InReady;
            hold_prev = OutValid && !OutReady;
            out_prev  = Out;
            step();
            cycles++;
        end
        check("rnd_accepted", 32'(accepted), 32'd1000);
        InValid = 1'b0; OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (OutValid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rnd_drain_extra: got output %0h, expected none", Out);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_drain_out", {24'd0, Out}, {24'd0, e});
                end
            end
            step();
        end
        check("rnd_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full; beat offered during reset must not be taken
        OutReady = 1'b0;
        drive(vecs[3]); step();
        drive(vecs[4]); step();
        check("mr_full_valid", {31'd0, OutValid}, 32'd1);
        drive(vecs[5]);
        reset = 1'b1;
        step();
        reset = 1'b0; OutReady = 1'b1;
        #1;
        check("mr_outvalid", {31'd0, OutValid}, 32'd0);
        check("mr_out", {24'd0, Out}, 32'd0);
        check("mr_out_sw", {24'd0, Out_sw}, 32'd0);
        check("mr_inready", {31'd0, InReady}, 32'd1);
        step();
        InValid = 1'b0;
        check("mr_lat1", {31'd0, OutValid}, 32'd0);
        step();
        check("mr_first_valid", {31'd0, OutValid}, 32'd1);
        check("mr_first_out", {24'd0, Out}, {24'd0, vecs[5].exp});
        step();
        check("mr_no_stale", {31'd0, OutValid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
